ps2_key_buffer: RTL and testbench

Receives raw PS/2 keyboard frames from the synchronized board pins and deserializes them. Validates start, parity and stop bits, and queues accepted scan-code bytes in a small FIFO. It sits directly upstream of the processor and drives its `ps2_key_pressed` / `ps2_out[7:0]` inputs, which the execute stage consumes on `tty` instructions. The FIFO keeps bytes from being lost while the pipeline stalls or is busy.

---
 rtl/ps2_key_buffer_pkg.sv | 16 +
 rtl/ps2_key_buffer_fifo.sv | 66 ++++++
 rtl/ps2_key_buffer.sv | 157 +++++++++++++++
 tb/tb_ps2_key_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_buffer_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: receiver states and
// the fixed frame layout (start, 8 data bits LSB first, odd parity, stop).
package ps2_key_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

    localparam logic PS2_START     = 1'b0;
    localparam logic PS2_STOP      = 1'b1;
    localparam int   PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_key_buffer_fifo.sv
// Small circular byte queue between the PS/2 receiver and the processor.
// A push into a full queue is dropped (with a one-cycle overflow pulse) unless
// a pop happens in the same cycle, in which case both take effect.
module ps2_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign do_push = push && (!full || do_pop);

    // Head byte straight from storage; stale storage is masked while empty.
    assign dout = empty ? 8'h00 : mem[rd_ptr];

    // Storage array: written only on accepted pushes, contents hidden when empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the overflow pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
            overflow <= push && full && !do_pop;
        end
    end

endmodule

// File: rtl/ps2_key_buffer.sv
// PS/2 keyboard receiver: synchronizes the raw pins, deserializes frames on
// falling PS/2 clock edges, validates start/parity/stop, aborts stalled frames
// and queues good scan-code bytes for the processor.
module ps2_key_buffer
    import ps2_key_buffer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_clk_in,
    input  logic                          ps2_data_in,
    input  logic                          key_ack,
    output logic                          ps2_key_pressed,
    output logic [7:0]                    ps2_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_error,
    output logic                          frame_error,
    output logic                          overflow
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             clk_sync_p0, clk_sync_p1, clk_prev_p2;
    logic             data_sync_p0, data_sync_p1;
    logic             fall;
    logic             bit_in;

    ps2_rx_state_t    state, state_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shreg, shreg_n;
    logic             parity_bit, parity_bit_n;
    logic [TMR_W-1:0] tmr;
    logic             timeout;
    logic             push;
    logic             perr_n, ferr_n;
    logic             fifo_empty;

    // ---- stage p0/p1: two-flop synchronizers; p2: previous clock level ----
    // Reset to the idle line level so leaving reset never fakes a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            clk_prev_p2  <= 1'b1;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
        end else begin
            clk_sync_p0  <= ps2_clk_in;
            clk_sync_p1  <= clk_sync_p0;
            clk_prev_p2  <= clk_sync_p1;
            data_sync_p0 <= ps2_data_in;
            data_sync_p1 <= data_sync_p0;
        end
    end

    // Data travels through the same depth as the clock, so it lines up with fall.
    assign fall    = clk_prev_p2 && !clk_sync_p1;
    assign bit_in  = data_sync_p1;
    assign timeout = (state != IDLE) && (tmr == TMR_W'(TIMEOUT_CYCLES));

    // Receiver next-state: advances only on fall; a stalled frame is abandoned.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        parity_bit_n = parity_bit;
        push         = 1'b0;
        perr_n       = 1'b0;
        ferr_n       = 1'b0;
        if (timeout) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (bit_in == PS2_START) begin
                        state_n   = DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                DATA: begin
                    shreg_n   = {bit_in, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    parity_bit_n = bit_in;
                    state_n      = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    // A bad stop bit outranks a parity mismatch.
                    if (bit_in == PS2_STOP) begin
                        if ((^shreg) ^ parity_bit) begin
                            push = 1'b1;
                        end else begin
                            perr_n = 1'b1;
                        end
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // ---- stage: receiver state, shift register and registered error pulses ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            shreg        <= 8'h00;
            parity_bit   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            shreg        <= shreg_n;
            parity_bit   <= parity_bit_n;
            parity_error <= perr_n;
            frame_error  <= ferr_n;
        end
    end

    // Inter-edge watchdog: restarts on each fall, idles at zero outside a frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmr <= '0;
        end else if (fall || timeout || state == IDLE) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (key_ack),
        .din      (shreg),
        .dout     (ps2_out),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign ps2_key_pressed = !fifo_empty;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Randomized and directed bench for ps2_key_buffer against a queue-based model.
module tb_ps2_key_buffer;
    localparam int DEPTH = 8;
    localparam int TO    = 100;
    localparam int H     = 12;   // PS/2 half bit period in system clocks

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_data_in = 1'b1;
    logic       key_ack = 1'b0;
    logic       ps2_key_pressed;
    logic [7:0] ps2_out;
    logic [3:0] fifo_count;
    logic       parity_error, frame_error, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    int seen_perr = 0, seen_ferr = 0, seen_ovf = 0;

    ps2_key_buffer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .key_ack(key_ack), .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
        .fifo_count(fifo_count), .parity_error(parity_error), .frame_error(frame_error),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Every high cycle of a pulse is counted, so a stretched pulse shows up.
    always @(posedge clock) begin
        if (parity_error === 1'b1) seen_perr <= seen_perr + 1;
        if (frame_error  === 1'b1) seen_ferr <= seen_ferr + 1;
        if (overflow     === 1'b1) seen_ovf  <= seen_ovf + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (q.size() != 0) ? q[0] : 8'h00;
        chk({tag, ".pressed"}, 32'(ps2_key_pressed), 32'(q.size() != 0));
        chk({tag, ".out"},     32'(ps2_out),         32'(head));
        chk({tag, ".count"},   32'(fifo_count),      32'(q.size()));
        chk({tag, ".perr"},    32'(seen_perr),       32'(exp_perr));
        chk({tag, ".ferr"},    32'(seen_ferr),       32'(exp_ferr));
        chk({tag, ".ovf"},     32'(seen_ovf),        32'(exp_ovf));
    endtask

    // One PS/2 bit; with ack set, key_ack is raised for the cycle the
    // receiver acts on this falling edge (three clocks after the pin drops).
    task automatic ps2_bit(input logic b, input bit ack);
        @(negedge clock);
        ps2_data_in = b;
        repeat (H / 2) @(negedge clock);
        ps2_clk_in = 1'b0;
        if (ack) begin
            repeat (2) @(negedge clock);
            key_ack = 1'b1;
            @(negedge clock);
            key_ack = 1'b0;
            repeat (H - 3) @(negedge clock);
        end else begin
            repeat (H) @(negedge clock);
        end
        ps2_clk_in = 1'b1;
        repeat (H / 2) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                              input int nbits, input bit ack_stop);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i], 1'b0);
        if (nbits == 8) begin
            ps2_bit((~^d) ^ bad_par, 1'b0);
            ps2_bit(stop, ack_stop);
        end
    endtask

    // Model of a complete frame's effect on the queue and pulse counters.
    task automatic model_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                               input bit ack_stop);
        if (ack_stop && q.size() != 0) void'(q.pop_front());
        if (!stop) exp_ferr++;
        else if (bad_par) exp_perr++;
        else if (q.size() < DEPTH) q.push_back(d);
        else exp_ovf++;
    endtask

    task automatic frame(input logic [7:0] d, input bit bad_par, input logic stop,
                         input bit ack_stop);
        send_frame(d, bad_par, stop, 8, ack_stop);
        model_frame(d, bad_par, stop, ack_stop);
    endtask

    task automatic pop_one();
        @(negedge clock);
        key_ack = 1'b1;
        @(negedge clock);
        key_ack = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_state("reset_hold");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_state("reset_release");

        // Single good byte, then acknowledge it.
        frame(8'h1C, 0, 1'b1, 0);
        check_state("good_1c");
        pop_one();
        check_state("ack_1c");

        // Parity error followed by a good frame.
        frame(8'h1C, 1, 1'b1, 0);
        check_state("parity_err");
        frame(8'hF0, 0, 1'b1, 0);
        check_state("after_perr_f0");
        pop_one();

        // Bad stop bit with bad parity reports only the frame error.
        frame(8'h33, 1, 1'b0, 0);
        check_state("bad_stop");

        // Overflow on the ninth byte, then drain in order.
        for (int i = 1; i <= 9; i++) frame(8'(i), 0, 1'b1, 0);
        check_state("overflow");
        for (int i = 0; i < 8; i++) begin
            pop_one();
            check_state($sformatf("drain%0d", i));
        end
        pop_one();
        check_state("pop_empty");

        // Timeout after four data bits, then recovery.
        send_frame(8'hA5, 0, 1'b1, 4, 0);
        repeat (TO + 5) @(negedge clock);
        exp_ferr++;
        check_state("timeout");
        frame(8'h5A, 0, 1'b1, 0);
        check_state("after_timeout_5a");
        pop_one();

        // Full queue with a pop in the push cycle, then drain across the wrap.
        for (int i = 0; i < DEPTH; i++) frame(8'($urandom_range(0, 255)), 0, 1'b1, 0);
        frame(8'hC3, 0, 1'b1, 1);
        check_state("push_pop_full");
        while (q.size() != 0) begin
            pop_one();
            check_state("wrap_drain");
        end

        // Reset mid-frame with bytes queued.
        for (int i = 0; i < 3; i++) frame(8'($urandom_range(0, 255)), 0, 1'b1, 0);
        send_frame(8'h77, 0, 1'b1, 5, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        chk("midreset.pressed", 32'(ps2_key_pressed), 32'd0);
        chk("midreset.out",     32'(ps2_out),         32'd0);
        chk("midreset.count",   32'(fifo_count),      32'd0);
        chk("midreset.pulses",  32'({parity_error, frame_error, overflow}), 32'd0);
        repeat (4) @(negedge clock);
        check_state("midreset_idle");
        frame(8'h29, 0, 1'b1, 0);
        check_state("after_reset_29");

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 4) frame(8'($urandom_range(0, 255)), 0, 1'b1, $urandom_range(0, 3) == 0);
            else if (kind == 5) frame(8'($urandom_range(0, 255)), 1, 1'b1, 0);
            else if (kind == 6) frame(8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1, 1'b0, 0);
            else pop_one();
            check_state($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
